// File: rtl/cs015_display_scan_pkg.sv
// rtl/cs015_display_scan_pkg.sv - segment codes and digit-enable constants for the display scanner
package cs015_display_scan_pkg;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] AN_UNITS  = 2'b01;
  localparam logic [1:0] AN_TENS   = 2'b10;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - decimal digit to active-high 7-segment code, blank for 10..15
module bcd_to_7seg
  import cs015_display_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cs015_display_scan.sv
// rtl/cs015_display_scan.sv - samples a 0..15 count, scans it onto two 7-segment digits, counts wraps
module cs015_display_scan
  import cs015_display_scan_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int WRAP_W   = 4
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic [3:0]        Q,
  output logic [6:0]        seg,
  output logic [1:0]        an,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam int              PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [3:0]        q_r_q, q_r_d;
  logic [PRE_W-1:0]  prescaler_q, prescaler_d;
  logic              digit_sel_q, digit_sel_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic              tens;
  logic [3:0]        units;
  logic [3:0]        digit_mux;
  logic [6:0]        dec_seg;

  always_comb begin
    q_r_d       = Q;
    wrap_d      = (q_r_q == 4'hF) && (Q == 4'h0);
    wrap_cnt_d  = wrap_cnt_q + WRAP_W'(wrap_d);
    prescaler_d = prescaler_q + PRE_W'(1);
    digit_sel_d = digit_sel_q;
    if (prescaler_q == PRE_LAST) begin
      prescaler_d = '0;
      digit_sel_d = ~digit_sel_q;
    end
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      q_r_q       <= 4'h0;
      prescaler_q <= '0;
      digit_sel_q <= 1'b0;
      wrap_q      <= 1'b0;
      wrap_cnt_q  <= '0;
    end else begin
      q_r_q       <= q_r_d;
      prescaler_q <= prescaler_d;
      digit_sel_q <= digit_sel_d;
      wrap_q      <= wrap_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  // Tens digit of a 0..15 value is only ever 0 or 1
  always_comb begin
    tens      = (q_r_q >= 4'd10);
    units     = tens ? (q_r_q - 4'd10) : q_r_q;
    digit_mux = digit_sel_q ? 4'd1 : units;
  end

  bcd_to_7seg u_dec (
    .digit (digit_mux),
    .seg   (dec_seg)
  );

  // Leading-zero blanking keeps the tens enable asserted but drives no segments
  always_comb begin
    an  = digit_sel_q ? AN_TENS : AN_UNITS;
    seg = (digit_sel_q && !tens) ? SEG_BLANK : dec_seg;
  end

  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_cs015_display_scan.sv
// tb/tb_cs015_display_scan.sv - table vectors and scoreboard checks for cs015_display_scan
module tb_cs015_display_scan;

  localparam int SCAN_DIV = 4;
  localparam int WRAP_W   = 2;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [11:0] RST_OUT = {S0, 2'b01, 1'b0, 2'b00};

  logic              clk = 1'b0;
  logic              CLR;
  logic [3:0]        Q;
  logic [6:0]        seg;
  logic [1:0]        an;
  logic              wrap;
  logic [WRAP_W-1:0] wrap_cnt;

  always #10 clk = ~clk;

  cs015_display_scan #(.SCAN_DIV(SCAN_DIV), .WRAP_W(WRAP_W)) dut (
    .clk      (clk),
    .CLR      (CLR),
    .Q        (Q),
    .seg      (seg),
    .an       (an),
    .wrap     (wrap),
    .wrap_cnt (wrap_cnt)
  );

  typedef struct packed {
    logic [3:0] q;
    logic [6:0] seg;
    logic [1:0] an;
  } vec_t;

  vec_t         tbl [19];
  logic [11:0]  sb [$];
  logic [6:0]   dec [10];
  int           n_vec  = 0;
  int           n_miss = 0;
  int           m_q, m_pre, m_sel, m_wrap, m_cnt;

  task automatic model_reset();
    m_q = 0; m_pre = 0; m_sel = 0; m_wrap = 0; m_cnt = 0;
  endtask

  function automatic logic [11:0] model_out();
    int         t, u;
    logic [6:0] s;
    t = (m_q >= 10) ? 1 : 0;
    u = (t != 0) ? m_q - 10 : m_q;
    if (m_sel != 0) s = (t != 0) ? dec[1] : 7'b0000000;
    else            s = dec[u];
    return {s, (m_sel != 0) ? 2'b10 : 2'b01, 1'(m_wrap), 2'(m_cnt)};
  endfunction

  task automatic model_step(input logic [3:0] q, output logic [11:0] e);
    m_wrap = (m_q == 15 && q == 4'd0) ? 1 : 0;
    if (m_wrap != 0) m_cnt = (m_cnt + 1) % (1 << WRAP_W);
    m_q = int'(q);
    if (m_pre == SCAN_DIV - 1) begin
      m_pre = 0;
      m_sel = 1 - m_sel;
    end else begin
      m_pre = m_pre + 1;
    end
    e = model_out();
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got seg=%b an=%b wrap=%b cnt=%0d, want seg=%b an=%b wrap=%b cnt=%0d",
               name, act[11:5], act[4:3], act[2], act[1:0], exp[11:5], exp[4:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive one Q value, predict the post-edge outputs, compare after the edge
  task automatic step(input logic [3:0] q, input logic use_tbl, input logic [11:0] tbl_exp,
                      input string name);
    logic [11:0] e;
    logic [11:0] want;
    Q = q;
    model_step(q, e);
    sb.push_back(use_tbl ? tbl_exp : e);
    @(posedge clk);
    @(negedge clk);
    want = sb.pop_front();
    check(name, {seg, an, wrap, wrap_cnt}, want);
  endtask

  initial begin
    dec = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    for (int i = 0; i < 19; i++) begin
      if (i < 3)       tbl[i] = '{q: 4'd12, seg: S2,         an: 2'b01};
      else if (i < 7)  tbl[i] = '{q: 4'd12, seg: S1,         an: 2'b10};
      else if (i < 11) tbl[i] = '{q: 4'd12, seg: S2,         an: 2'b01};
      else if (i < 15) tbl[i] = '{q: 4'd7,  seg: 7'b0000000, an: 2'b10};
      else             tbl[i] = '{q: 4'd7,  seg: S7,         an: 2'b01};
    end

    // Reset held with a nonzero Q
    CLR = 1'b0;
    Q   = 4'h9;
    model_reset();
    #5;
    check("reset_t5", {seg, an, wrap, wrap_cnt}, RST_OUT);
    @(negedge clk);
    check("reset_hold1", {seg, an, wrap, wrap_cnt}, RST_OUT);
    @(negedge clk);
    check("reset_hold2", {seg, an, wrap, wrap_cnt}, RST_OUT);
    CLR = 1'b1;

    // Static display of 12 then 7 with leading-zero blanking
    for (int i = 0; i < 19; i++)
      step(tbl[i].q, 1'b1, {tbl[i].seg, tbl[i].an, 1'b0, 2'b00}, $sformatf("tbl_%0d", i));

    // Free-running count 0..15 then back to 0 (7->0 at the start is not a wrap)
    for (int v = 0; v < 16; v++)
      step(4'(v), 1'b0, 12'h0, $sformatf("run_%0d", v));
    step(4'd0, 1'b0, 12'h0, "run_wrap");
    check_val("run_wrap_pulse", int'(wrap), 1);
    check_val("run_wrap_cnt", int'(wrap_cnt), 1);
    step(4'd1, 1'b0, 12'h0, "run_after");
    check_val("run_pulse_one_cycle", int'(wrap), 0);

    // Preset and clear jumps
    step(4'd3, 1'b0, 12'h0, "preset_a");
    step(4'd15, 1'b0, 12'h0, "preset_b");
    check_val("preset_no_wrap", int'(wrap), 0);
    step(4'd0, 1'b0, 12'h0, "clear_15_0");
    check_val("clear_wrap", int'(wrap), 1);
    check_val("clear_cnt", int'(wrap_cnt), 2);
    step(4'd7, 1'b0, 12'h0, "jump_a");
    step(4'd0, 1'b0, 12'h0, "jump_7_0");
    check_val("jump_no_wrap", int'(wrap), 0);
    check_val("jump_cnt", int'(wrap_cnt), 2);

    // Rollover of a 2-bit wrap counter from a clean reset
    CLR = 1'b0;
    model_reset();
    #1;
    check("rst_before_roll", {seg, an, wrap, wrap_cnt}, RST_OUT);
    @(negedge clk);
    CLR = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(4'd15, 1'b0, 12'h0, $sformatf("roll_pre_%0d", k));
      step(4'd0, 1'b0, 12'h0, $sformatf("roll_wrap_%0d", k));
      check_val($sformatf("roll_cnt_%0d", k), int'(wrap_cnt), (k + 1) % 4);
    end

    // Park on the tens digit with q_r=15, then reset asynchronously while Q=0
    for (int k = 0; k < 8; k++) begin
      step(4'd15, 1'b0, 12'h0, $sformatf("park_%0d", k));
      if (m_sel == 1) break;
    end
    check_val("park_on_tens", int'(an), 2);
    #3;
    CLR = 1'b0;
    Q   = 4'd0;
    model_reset();
    #1;
    check("async_reset", {seg, an, wrap, wrap_cnt}, RST_OUT);
    @(posedge clk);
    @(negedge clk);
    check("reset_beats_wrap", {seg, an, wrap, wrap_cnt}, RST_OUT);
    CLR = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(4'd5, 1'b0, 12'h0, $sformatf("restart_%0d", k));
      check_val($sformatf("restart_an_%0d", k), int'(an), (k >= 3 && k < 7) ? 2 : 1);
    end

    check_val("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
